// File: rtl/dmem_arbiter.sv
// Two-port valid/ready arbiter and one-access sequencer for the single-ported data memory.
// Build option: define DMEM_ARB_FIXED_PRIO_EN for fixed priority (port 0 wins contention).
module dmem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic              req0_we,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    output logic              rsp0_valid,
    output logic [DATA_W-1:0] rsp0_rdata,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic              req1_we,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    output logic              rsp1_valid,
    output logic [DATA_W-1:0] rsp1_rdata,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t              state_q;
    logic                we_q;
    logic                id_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [DATA_W-1:0]   rsp0_rdata_q;
    logic [DATA_W-1:0]   rsp1_rdata_q;
`ifndef DMEM_ARB_FIXED_PRIO_EN
    logic                last_q;
`endif

    logic                arb_en;
    logic                grant0;
    logic                grant1;
    logic                accept;

    // Arbitration is open only between accesses; the winner sees ready in the same cycle.
    always_comb begin
        arb_en = !rst && ((state_q == IDLE) || (state_q == RESP));
`ifdef DMEM_ARB_FIXED_PRIO_EN
        grant0 = req0_valid;
`else
        grant0 = req0_valid && (!req1_valid || last_q);
`endif
        grant1     = req1_valid && !grant0;
        req0_ready = arb_en && grant0;
        req1_ready = arb_en && grant1;
        accept     = req0_ready || req1_ready;
    end

    // Sequencer: latch the winner, perform one memory cycle, then present the response.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            we_q         <= 1'b0;
            id_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            rsp0_rdata_q <= '0;
            rsp1_rdata_q <= '0;
`ifndef DMEM_ARB_FIXED_PRIO_EN
            last_q       <= 1'b1;
`endif
        end else begin
            case (state_q)
                IDLE, RESP: begin
                    if (accept) begin
                        we_q    <= req1_ready ? req1_we    : req0_we;
                        addr_q  <= req1_ready ? req1_addr  : req0_addr;
                        wdata_q <= req1_ready ? req1_wdata : req0_wdata;
                        id_q    <= req1_ready;
`ifndef DMEM_ARB_FIXED_PRIO_EN
                        last_q  <= req1_ready;
`endif
                        state_q <= ACCESS;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                ACCESS: begin
                    // Write acknowledges return zero data.
                    if (id_q) begin
                        rsp1_rdata_q <= we_q ? '0 : mem_rdata;
                    end else begin
                        rsp0_rdata_q <= we_q ? '0 : mem_rdata;
                    end
                    state_q <= RESP;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Strobes are qualified with rst so a reset during ACCESS never commits a write.
    assign mem_read   = !rst && (state_q == ACCESS) && !we_q;
    assign mem_write  = !rst && (state_q == ACCESS) && we_q;
    assign mem_addr   = addr_q;
    assign mem_wdata  = wdata_q;
    assign rsp0_valid = !rst && (state_q == RESP) && !id_q;
    assign rsp1_valid = !rst && (state_q == RESP) && id_q;
    assign rsp0_rdata = rsp0_rdata_q;
    assign rsp1_rdata = rsp1_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed vector table, corner sequences, randomized model check.
module tb_dmem_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          req0_valid, req0_ready, req0_we;
    logic [AW-1:0] req0_addr;
    logic [DW-1:0] req0_wdata;
    logic          rsp0_valid;
    logic [DW-1:0] rsp0_rdata;
    logic          req1_valid, req1_ready, req1_we;
    logic [AW-1:0] req1_addr;
    logic [DW-1:0] req1_wdata;
    logic          rsp1_valid;
    logic [DW-1:0] rsp1_rdata;
    logic          mem_read, mem_write;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    logic          mem_clr;
    logic [DW-1:0] mem_array [0:63];

    int errors = 0;
    int checks = 0;

    dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_we(req0_we),
        .req0_addr(req0_addr), .req0_wdata(req0_wdata),
        .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_we(req1_we),
        .req1_addr(req1_addr), .req1_wdata(req1_wdata),
        .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata),
        .mem_read(mem_read), .mem_write(mem_write),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Simple single-ported memory: combinational read, write on the clock edge.
    assign mem_rdata = mem_array[mem_addr[7:2]];
    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 64; i++) mem_array[i] <= '0;
        end else if (mem_write) begin
            mem_array[mem_addr[7:2]] <= mem_wdata;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive_port(input bit p, input bit v, input bit we,
                              input logic [31:0] a, input logic [31:0] d);
        if (p) begin
            req1_valid = v; req1_we = we; req1_addr = a; req1_wdata = d;
        end else begin
            req0_valid = v; req0_we = we; req0_addr = a; req0_wdata = d;
        end
    endtask

    function automatic logic rdy(input bit p);
        return p ? req1_ready : req0_ready;
    endfunction

    function automatic logic rspv(input bit p);
        return p ? rsp1_valid : rsp0_valid;
    endfunction

    function automatic logic [31:0] rspd(input bit p);
        return p ? rsp1_rdata : rsp0_rdata;
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        drive_port(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive_port(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Single transaction from an idle arbiter: accept at T, access at T+1, response at T+2.
    task automatic do_txn(input bit p, input bit we, input logic [31:0] a,
                          input logic [31:0] d, input logic [31:0] exp);
        drive_port(p, 1'b1, we, a, d);
        #1;
        check("txn_ready", rdy(p), 1'b1);
        check("txn_other_ready", rdy(!p), 1'b0);
        next_cycle();
        drive_port(p, 1'b0, 1'b0, 32'h0, 32'h0);
        #1;
        check("txn_mem_write", mem_write, we);
        check("txn_mem_read", mem_read, !we);
        check("txn_mem_addr", mem_addr, a);
        if (we) check("txn_mem_wdata", mem_wdata, d);
        check("txn_no_early_rsp", {rsp0_valid, rsp1_valid}, 2'b00);
        next_cycle();
        #1;
        check("txn_rsp_valid", rspv(p), 1'b1);
        check("txn_other_rsp", rspv(!p), 1'b0);
        check("txn_rsp_rdata", rspd(p), exp);
        check("txn_resp_no_strobe", {mem_read, mem_write}, 2'b00);
        next_cycle();
    endtask

    typedef struct {
        bit          port;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl [6];

    // Transaction-level reference model state for the random phase.
    bit          pend [2];
    bit          pwe [2];
    logic [31:0] paddr [2];
    logic [31:0] pdata [2];
    logic [31:0] ref_mem [0:63];
    bit          last_m, acc_prev, prev_we;
    bit          due_a_v, due_a_p, due_b_v, due_b_p;
    logic [31:0] due_a_d, due_b_d;
    int          gseq [8];
    int          gcnt, last_gc;

    initial begin
        tbl[0] = '{1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 32'h0};
        tbl[1] = '{1'b0, 1'b0, 32'h10, 32'h0,        32'hDEADBEEF};
        tbl[2] = '{1'b1, 1'b1, 32'h20, 32'h12345678, 32'h0};
        tbl[3] = '{1'b1, 1'b1, 32'h24, 32'hCAFEF00D, 32'h0};
        tbl[4] = '{1'b1, 1'b0, 32'h20, 32'h0,        32'h12345678};
        tbl[5] = '{1'b0, 1'b0, 32'h14, 32'h0,        32'h0};

        mem_clr = 1'b1;
        rst = 1'b1;
        drive_port(1'b0, 1'b1, 1'b1, 32'hFC, 32'h1);
        drive_port(1'b1, 1'b1, 1'b1, 32'hF8, 32'h2);
        repeat (2) @(posedge clk);
        #2;
        mem_clr = 1'b0;
        check("rst_ready", {req0_ready, req1_ready}, 2'b00);
        check("rst_rsp_valid", {rsp0_valid, rsp1_valid}, 2'b00);
        check("rst_rsp_rdata", {rsp0_rdata, rsp1_rdata}, 64'h0);
        check("rst_mem_strobe", {mem_read, mem_write}, 2'b00);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_mem_wdata", mem_wdata, 32'h0);
        do_reset();

        for (int i = 0; i < 6; i++)
            do_txn(tbl[i].port, tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].exp);

        // Back-to-back port-1 reads: second ready coincides with first response.
        drive_port(1'b1, 1'b1, 1'b0, 32'h20, 32'h0);
        #1;
        check("b2b_ready_first", req1_ready, 1'b1);
        next_cycle();
        drive_port(1'b1, 1'b1, 1'b0, 32'h24, 32'h0);
        #1;
        check("b2b_no_ready_access", req1_ready, 1'b0);
        next_cycle();
        #1;
        check("b2b_rsp1_first", rsp1_valid, 1'b1);
        check("b2b_rdata_first", rsp1_rdata, 32'h12345678);
        check("b2b_ready_second", req1_ready, 1'b1);
        next_cycle();
        drive_port(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        #1;
        check("b2b_gap", rsp1_valid, 1'b0);
        check("b2b_access2", {mem_read, mem_addr}, {1'b1, 32'h24});
        next_cycle();
        #1;
        check("b2b_rsp1_second", rsp1_valid, 1'b1);
        check("b2b_rdata_second", rsp1_rdata, 32'hCAFEF00D);
        next_cycle();

        // Reset during the ACCESS cycle of a write discards it entirely.
        drive_port(1'b0, 1'b1, 1'b1, 32'h30, 32'h55AA55AA);
        #1;
        check("rsta_ready", req0_ready, 1'b1);
        next_cycle();
        drive_port(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        rst = 1'b1;
        #1;
        check("rsta_mem_write", mem_write, 1'b0);
        check("rsta_rsp", {rsp0_valid, rsp1_valid}, 2'b00);
        next_cycle();
        rst = 1'b0;
        #1;
        check("rsta_idle_rsp", {rsp0_valid, rsp1_valid}, 2'b00);
        check("rsta_idle_strobe", {mem_read, mem_write}, 2'b00);
        next_cycle();
        #1;
        check("rsta_no_late_rsp", {rsp0_valid, rsp1_valid}, 2'b00);
        do_txn(1'b0, 1'b0, 32'h30, 32'h0, 32'h0);
        do_txn(1'b0, 1'b1, 32'h30, 32'h55AA55AA, 32'h0);
        do_txn(1'b0, 1'b0, 32'h30, 32'h0, 32'h55AA55AA);

        // Continuous contention for 8 grants right after reset.
        do_reset();
        drive_port(1'b0, 1'b1, 1'b0, 32'h40, 32'h0);
        drive_port(1'b1, 1'b1, 1'b0, 32'h44, 32'h0);
        gcnt = 0;
        last_gc = 0;
        for (int c = 0; c < 40 && gcnt < 8; c++) begin
            #1;
            if (req0_ready && req1_ready) check("cont_both_ready", 2'b11, 2'b01);
            if (req0_ready || req1_ready) begin
                if (gcnt > 0) check("cont_spacing", c - last_gc, 2);
                gseq[gcnt] = req1_ready ? 1 : 0;
                gcnt++;
                last_gc = c;
            end
            next_cycle();
        end
        check("cont_grant_count", gcnt, 8);
        for (int i = 0; i < 8; i++) begin
`ifdef DMEM_ARB_FIXED_PRIO_EN
            check("cont_grant_seq", gseq[i], 0);
`else
            check("cont_grant_seq", gseq[i], i % 2);
`endif
        end
        drive_port(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive_port(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        repeat (3) next_cycle();

        // Randomized traffic against a transaction-level model.
        do_reset();
        for (int i = 0; i < 64; i++) ref_mem[i] = '0;
        pend[0] = 1'b0; pend[1] = 1'b0;
        last_m = 1'b1; acc_prev = 1'b0; prev_we = 1'b0;
        due_a_v = 1'b0; due_b_v = 1'b0; due_a_p = 1'b0; due_b_p = 1'b0;
        due_a_d = '0; due_b_d = '0;
        for (int c = 0; c < 400; c++) begin
            bit win, acc, b0, b1;
            logic [31:0] rd;
            for (int p = 0; p < 2; p++) begin
                if (!pend[p] && $urandom_range(0, 2) != 0) begin
                    pend[p]  = 1'b1;
                    pwe[p]   = 1'($urandom_range(0, 1));
                    paddr[p] = 32'h80 + 32'($urandom_range(0, 15)) * 32'd4;
                    pdata[p] = $urandom;
                end
                drive_port(p[0], pend[p], pwe[p], paddr[p], pdata[p]);
            end
            #1;
            b0  = pend[0];
            b1  = pend[1];
            acc = !acc_prev && (b0 || b1);
`ifdef DMEM_ARB_FIXED_PRIO_EN
            win = !b0;
`else
            win = (b0 && b1) ? !last_m : !b0;
`endif
            check("rnd_ready0", req0_ready, acc && !win);
            check("rnd_ready1", req1_ready, acc && win);
            check("rnd_rsp0_valid", rsp0_valid, due_a_v && !due_a_p);
            check("rnd_rsp1_valid", rsp1_valid, due_a_v && due_a_p);
            if (due_a_v) check("rnd_rsp_rdata", rspd(due_a_p), due_a_d);
            check("rnd_mem_write", mem_write, acc_prev && prev_we);
            check("rnd_mem_read", mem_read, acc_prev && !prev_we);
            due_a_v = due_b_v; due_a_p = due_b_p; due_a_d = due_b_d;
            due_b_v = 1'b0;
            if (acc) begin
                rd = pwe[win] ? 32'h0 : ref_mem[paddr[win][7:2]];
                if (pwe[win]) ref_mem[paddr[win][7:2]] = pdata[win];
                due_b_v = 1'b1; due_b_p = win; due_b_d = rd;
                last_m  = win;
                prev_we = pwe[win];
                pend[win] = 1'b0;
            end
            acc_prev = acc;
            next_cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-requester arbiter and sequencer for the single-ported data memory. Port 0 is the core load/store unit and port 1 is a debug/DMA master. The block accepts one request per grant with a valid/ready handshake. It drives the memory's read, write, address and write-data inputs for exactly one cycle per access, then returns a registered response to the winning port.

## Interface
Parameters:
- ADDR_W, 32, width of request and memory address
- DATA_W, 32, width of write data, read data and responses

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- req0_valid  in  1  port 0 request present
- req0_ready  out  1  port 0 request accepted this cycle
- req0_we  in  1  1 = write, 0 = read
- req0_addr  in  ADDR_W  byte address, passed to memory unchanged
- req0_wdata  in  DATA_W  write data
- rsp0_valid  out  1  one-cycle response pulse to port 0
- rsp0_rdata  out  DATA_W  read data; 0 for write acknowledges
- req1_*, rsp1_*  same set as port 0, for port 1
- mem_read  out  1  memory read enable
- mem_write  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data; combinational, valid in the same cycle as mem_read

## Operation
- FSM states: IDLE, ACCESS, RESP. Reset state is IDLE.
- Acceptance:
  - Arbitration runs only in IDLE and RESP.
  - If any reqN_valid is high, exactly one reqN_ready is asserted combinationally in that cycle.
  - On acceptance, the winner's we/addr/wdata and the port id are latched, and the FSM goes to ACCESS.
  - With no request, RESP goes to IDLE and IDLE stays in IDLE.
- ACCESS:
  - mem_addr and mem_wdata come from the latched values.
  - mem_read = !we and mem_write = we, each for this single cycle.
  - On a read, mem_rdata is captured into the response register. On a write, the response register is loaded with 0.
  - Next state is always RESP.
- RESP:
  - rsp<id>_valid is high for this one cycle and the other port's rsp_valid stays low.
  - rsp<id>_rdata holds the captured value.
  - A new request may be accepted in the same cycle.
- Round-robin:
  - A last-grant pointer is updated on every acceptance.
  - When both ports are valid, the port not granted last wins.
  - When only one port is valid, that port wins regardless of the pointer.
  - The reset value of the pointer is "port 1 last", so port 0 wins the first contention.
- Requesters must hold valid, we, addr and wdata stable until ready is seen. The arbiter never drops an asserted valid, and a port losing arbitration simply waits.
- Outside ACCESS, mem_read and mem_write are 0. mem_addr and mem_wdata hold their last latched values; they are don't-care for memory.
- Addresses are not checked for alignment; the memory word-indexes them itself.

## Timing
- Reset values: all reqN_ready = 0, rspN_valid = 0, rspN_rdata = 0, mem_read = 0, mem_write = 0, mem_addr = 0, mem_wdata = 0. While rst is high, no ready is asserted.
- Latency: a request accepted at cycle T has its memory access at T+1 and its response at T+2.
- Throughput: one access per 2 cycles under continuous requests.
- Simultaneous valid on both ports: exactly one ready, decided by the round-robin pointer.
- Reset asserted in ACCESS or RESP: the in-flight transaction is discarded with no response. mem_write is forced 0 in the reset cycle, and the next cycle is IDLE.
- A response and a new acceptance in the same RESP cycle are legal. The response belongs to the previous transaction.

## Configuration
- DMEM_ARB_FIXED_PRIO_EN
  - Defined: fixed priority, where port 0 always wins contention. The last-grant pointer is not implemented.
  - Undefined (default): round-robin as specified above.
- Timing and the handshake are identical in both builds.

## Test plan
- Single port-0 write, addr 0x10, data 0xDEADBEEF, accepted at T:
  - mem_write=1, mem_addr=0x10 at T+1.
  - rsp0_valid=1, rsp0_rdata=0 at T+2.
- Port-0 read of addr 0x10 after the write above, with the memory model returning 0xDEADBEEF:
  - mem_read=1 at T+1.
  - rsp0_valid=1, rsp0_rdata=0xDEADBEEF at T+2.
  - rsp1_valid stays 0.
- Both ports continuously valid for 8 grants:
  - Round-robin build: grants alternate 0,1,0,1,…, starting with 0 after reset, one every 2 cycles.
  - Fixed-priority build: port 0 gets all grants.
- Back-to-back port-1 reads of 0x20 and 0x24:
  - The second ready is asserted in the same cycle as the first rsp1_valid.
  - Responses are 2 cycles apart.
- rst asserted during ACCESS of a write:
  - mem_write=0 in the reset cycle and no rspN_valid.
  - IDLE the next cycle; a subsequent request completes normally.
